// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS instruction field positions and IF/ID state encoding
//
// Purpose: constants used by the IF/ID stage and its skid buffer.
//   INSTR_W            instruction word width
//   *_MSB / *_LSB      bit positions of each MIPS instruction field
//   ifid_state_t       occupancy state of the 2-entry skid buffer
package mips_pkg;

  localparam int INSTR_W   = 32;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_MSB = 25;
  localparam int JADDR_LSB = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ifid_state_t;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - generic 2-entry valid/ready skid register with flush
//
// Purpose: holds up to two data words between a producer and a consumer.
// The main entry always drives out_data; the skid entry catches one word that
// arrives while the consumer is stalled. in_ready is a registered flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop all held entries (state -> EMPTY)
//   in_valid/in_ready   producer handshake, in_data payload
//   out_valid/out_ready consumer handshake, out_data payload (main entry)
module skid_buffer
  import mips_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  ifid_state_t state, state_nx;
  logic [W-1:0] main_q, skid_q;
  logic         in_ready_q;
  logic         in_fire, out_fire;
  logic         load_main_in, load_main_skid, load_skid;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = (state != EMPTY) & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nx     = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so no input can arrive alongside the drain.
        if (out_fire) begin
          state_nx       = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // A redirect wins over everything: drop held words and any incoming one.
    if (flush) begin
      state_nx       = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != FULL);
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ifid_stage.sv
// rtl/ifid_stage.sv - MIPS IF/ID pipeline register with skid buffer and field decode
//
// Purpose: registers fetched instruction + PC behind a valid/ready handshake
// and slices the held instruction into MIPS fields for decode.
// Optional feature macro: IFID_STALL_COUNT_EN (adds saturating stall_count).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      branch/jump redirect, discards held instructions
//   in_valid/in_ready          fetch handshake; in_instr, in_pc payload
//   out_valid/out_ready        decode handshake; out_instr, out_pc payload
//   opcode rs rt rd shamt funct imm16 jaddr   fields of out_instr
//   stall_count                cycles with out_valid & !out_ready (optional)
module ifid_stage
  import mips_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [25:0]       jaddr
`ifdef IFID_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  logic [INSTR_W+PC_W-1:0] held;

  skid_buffer #(
    .W (INSTR_W + PC_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_instr, in_pc}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (held)
  );

  assign out_instr = held[INSTR_W+PC_W-1:PC_W];
  assign out_pc    = held[PC_W-1:0];

  // Field slices are don't-care while EMPTY (they show stale main contents).
  assign opcode = out_instr[OPC_MSB:OPC_LSB];
  assign rs     = out_instr[RS_MSB:RS_LSB];
  assign rt     = out_instr[RT_MSB:RT_LSB];
  assign rd     = out_instr[RD_MSB:RD_LSB];
  assign shamt  = out_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = out_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = out_instr[IMM_MSB:IMM_LSB];
  assign jaddr  = out_instr[JADDR_MSB:JADDR_LSB];

`ifdef IFID_STALL_COUNT_EN
  // Saturating; flush deliberately leaves it alone so stall history survives redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// tb/tb_ifid_stage.sv - self-checking bench for ifid_stage
module tb_ifid_stage;

  localparam int TB_CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jaddr;
`ifdef IFID_STALL_COUNT_EN
  logic [TB_CNT_W-1:0] stall_count;
`endif

  ifid_stage #(.PC_W(32), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .jaddr(jaddr)
`ifdef IFID_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        chk;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t        tbl[24];
  logic [63:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                              input logic ordy, input logic fl, input logic chk,
                              input logic ev, input logic er, input logic [31:0] ei);
    vec_t v;
    v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.chk = chk; v.exp_valid = ev; v.exp_ready = er; v.exp_instr = ei;
    return v;
  endfunction

  // Called at posedge+1: drive, sample at negedge, update scoreboard, return at next posedge+1.
  task automatic cycle(input vec_t v);
    logic [63:0] e;
    in_valid = v.iv; in_instr = v.instr; in_pc = v.pc; out_ready = v.ordy; flush = v.fl;
    @(negedge clk);
    check("sb_out_valid", {63'd0, out_valid}, {63'd0, (sb.size() > 0)});
    check("sb_in_ready", {63'd0, in_ready}, {63'd0, (sb.size() < 2)});
    if (v.chk) begin
      check("tbl_out_valid", {63'd0, out_valid}, {63'd0, v.exp_valid});
      check("tbl_in_ready", {63'd0, in_ready}, {63'd0, v.exp_ready});
      if (v.exp_valid) begin
        check("tbl_out_instr", {32'd0, out_instr}, {32'd0, v.exp_instr});
        check("fld_opcode", {58'd0, opcode}, {58'd0, v.exp_instr[31:26]});
        check("fld_rs", {59'd0, rs}, {59'd0, v.exp_instr[25:21]});
        check("fld_rt", {59'd0, rt}, {59'd0, v.exp_instr[20:16]});
        check("fld_rd_shamt_funct", {48'd0, rd, shamt, funct}, {48'd0, v.exp_instr[15:0]});
        check("fld_jaddr", {38'd0, jaddr}, {38'd0, v.exp_instr[25:0]});
        check("signext", {32'd0, {{16{imm16[15]}}, imm16}},
              {32'd0, {{16{v.exp_instr[15]}}, v.exp_instr[15:0]}});
      end
    end
    if (v.fl) begin
      sb.delete();
    end else begin
      if (out_valid && v.ordy) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", {32'd0, out_instr}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_instr_pc", {out_instr, out_pc}, e);
        end
      end
      if (v.iv && in_ready) sb.push_back({v.instr, v.pc});
    end
    @(posedge clk);
    #1;
  endtask

  vec_t idle0, idle1;

  initial begin
    idle0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle1 = mk(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // first instruction and decode
    tbl[0]  = mk(1, 32'h2008FFFF, 32'h400, 1, 0, 1, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 1, 1, 1, 32'h2008FFFF);
    // streaming
    tbl[2]  = mk(1, 32'h8C410004, 32'h404, 1, 0, 1, 0, 1, 0);
    tbl[3]  = mk(1, 32'h00221820, 32'h408, 1, 0, 1, 1, 1, 32'h8C410004);
    tbl[4]  = mk(1, 32'hAC430008, 32'h40C, 1, 0, 1, 1, 1, 32'h00221820);
    tbl[5]  = mk(1, 32'h08000100, 32'h410, 1, 0, 1, 1, 1, 32'hAC430008);
    tbl[6]  = mk(0, 0, 0, 1, 0, 1, 1, 1, 32'h08000100);
    tbl[7]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 0);
    // backpressure A, B
    tbl[8]  = mk(1, 32'hAAAA0001, 32'h500, 0, 0, 1, 0, 1, 0);
    tbl[9]  = mk(1, 32'hBBBB0002, 32'h504, 0, 0, 1, 1, 1, 32'hAAAA0001);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 1, 0, 32'hAAAA0001);
    tbl[11] = mk(0, 0, 0, 1, 0, 1, 1, 0, 32'hAAAA0001);
    tbl[12] = mk(0, 0, 0, 1, 0, 1, 1, 1, 32'hBBBB0002);
    tbl[13] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0);
    // flush while FULL with C offered
    tbl[14] = mk(1, 32'hA2A20003, 32'h600, 0, 0, 1, 0, 1, 0);
    tbl[15] = mk(1, 32'hB2B20004, 32'h604, 0, 0, 1, 1, 1, 32'hA2A20003);
    tbl[16] = mk(1, 32'hCCCC0005, 32'h608, 0, 1, 1, 1, 0, 32'hA2A20003);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0);
    // flush in ONE overrides an accepted input E
    tbl[18] = mk(1, 32'hDDDD0006, 32'h700, 1, 0, 1, 0, 1, 0);
    tbl[19] = mk(1, 32'hEEEE0007, 32'h704, 0, 1, 1, 1, 1, 32'hDDDD0006);
    tbl[20] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[21] = mk(1, 32'hFFFF0008, 32'h708, 1, 0, 1, 0, 1, 0);
    tbl[22] = mk(0, 0, 0, 1, 0, 1, 1, 1, 32'hFFFF0008);
    tbl[23] = mk(0, 0, 0, 1, 0, 1, 0, 1, 0);

    rst_n = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_instr_pc", {out_instr, out_pc}, 64'd0);
    rst_n = 1;

    for (int i = 0; i < 24; i++) cycle(tbl[i]);
    // explicit decode of 2008FFFF: addi $t0, $zero, -1
    cycle(mk(1, 32'h2008FFFF, 32'h800, 1, 0, 0, 0, 0, 0));
    check("addi_opcode", {58'd0, opcode}, 64'h08);
    check("addi_rs_rt", {54'd0, rs, rt}, {54'd0, 5'd0, 5'd8});
    check("addi_sext", {32'd0, {{16{imm16[15]}}, imm16}}, 64'h0000_0000_FFFF_FFFF);
    cycle(idle1);

    // async reset while FULL
    cycle(mk(1, 32'h12340009, 32'h900, 0, 0, 0, 0, 0, 0));
    cycle(mk(1, 32'h5678000A, 32'h904, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_out_instr", {32'd0, out_instr}, 64'd0);
`ifdef IFID_STALL_COUNT_EN
    check("arst_stall_count", {{(64-TB_CNT_W){1'b0}}, stall_count}, 64'd0);
`endif
    sb.delete();
    in_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    cycle(mk(1, 32'h9ABC000B, 32'hA00, 1, 0, 0, 0, 0, 0));
    cycle(mk(0, 0, 0, 1, 0, 1, 1, 1, 32'h9ABC000B));
    cycle(idle1);

`ifdef IFID_STALL_COUNT_EN
    cycle(mk(1, 32'h0000000C, 32'hB00, 0, 0, 0, 0, 0, 0));
    repeat (5) cycle(idle0);
    check("stall_count_5", {{(64-TB_CNT_W){1'b0}}, stall_count}, 64'd5);
    cycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    check("stall_after_flush", {{(64-TB_CNT_W){1'b0}}, stall_count}, 64'd5);
    cycle(mk(1, 32'h0000000D, 32'hB04, 0, 0, 0, 0, 0, 0));
    repeat (20) cycle(idle0);
    check("stall_saturate", {{(64-TB_CNT_W){1'b0}}, stall_count}, 64'd15);
    cycle(idle1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
- IF/ID pipeline stage of the MIPS datapath, sitting between instruction fetch and decode.
- Registers each fetched 32-bit instruction and its PC behind a valid/ready handshake, using a 2-entry skid buffer.
- Splits the held instruction into MIPS fields; imm16 drives the in16 input of signextend directly.
- Supports pipeline flush for branches and jumps.

Parameters:
- PC_W, 32, width of the program counter carried alongside the instruction.
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all held instructions (branch/jump redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  fetched instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decode-side instruction valid.
- out_ready  in  1  decode consumes this cycle.
- out_instr  out  32  held instruction (main entry).
- out_pc  out  PC_W  held PC (main entry).
- opcode  out  6  out_instr[31:26].
- rs  out  5  out_instr[25:21].
- rt  out  5  out_instr[20:16].
- rd  out  5  out_instr[15:11].
- shamt  out  5  out_instr[10:6].
- funct  out  6  out_instr[5:0].
- imm16  out  16  out_instr[15:0]; feeds signextend in16.
- jaddr  out  26  out_instr[25:0].
- stall_count  out  CNT_W  present only with IFID_STALL_COUNT_EN.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - main entry (instr, pc) drives the outputs.
  - skid entry holds one extra instruction.
- State machine states: EMPTY, ONE, FULL.
  - EMPTY: in_fire -> ONE (input loads into main).
  - ONE, in_fire & out_fire -> ONE (main replaced by input).
  - ONE, in_fire & !out_fire -> FULL (input loads into skid).
  - ONE, !in_fire & out_fire -> EMPTY.
  - FULL: out_fire -> ONE (skid moves to main); otherwise hold.
- Output status:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL); it is a registered flag updated with the state.
- Latency: an accepted instruction appears on out_* the next cycle. Throughput is 1 per cycle when out_ready is held high.
- Decoded fields: purely combinational slices of the main entry. When EMPTY they reflect the stale main contents and are don't-care.
- Data hold: while out_valid & !out_ready, out_instr/out_pc are stable. No entry is ever overwritten before it is consumed.
- flush:
  - Next state is EMPTY and in_ready = 1.
  - Overrides a simultaneous in_fire (that input is dropped) and any out_fire.
  - Data registers need not clear.
- Reset (asynchronous, any time, including mid-transfer):
  - state EMPTY, out_valid 0, in_ready 1.
  - main/skid instr and pc = 0, stall_count = 0.
  - First acceptance possible on the first rising edge after rst_n deasserts.
- Ordering: instructions leave in strict arrival order; no duplication, no loss except via flush.

Optional Feature:
- Macro: IFID_STALL_COUNT_EN.
- When defined:
  - stall_count port exists.
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at all-ones (no wrap).
  - Cleared by reset only; flush does not clear it.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - field bit positions (OPC_MSB/LSB, RS_*, RT_*, RD_*, SHAMT_*, FUNCT_*, IMM_*, JADDR_*).
  - state encoding typedef ifid_state_t {EMPTY, ONE, FULL}.
  - INSTR_W = 32.
- One natural sub-module: skid_buffer.
  - Generic 2-entry valid/ready register with flush, width = 32 + PC_W.
  - ifid_stage instantiates it and adds field slicing and the optional counter.

Test Plan:
- Reset, then in_valid=1 with in_instr=32'h2008FFFF, in_pc=0x400, out_ready=1 -> next cycle:
  - out_valid=1, opcode=6'h08, rs=0, rt=8, imm16=16'hFFFF.
  - Downstream signextend yields 32'hFFFFFFFF.
- Streaming: 4 back-to-back instructions with out_ready=1 -> emerge in order, one per cycle, in_ready stays 1.
- Backpressure:
  - out_ready=0 while sending A, B -> after B, in_ready=0 and out holds A.
  - Raise out_ready -> A then B delivered, in_ready back to 1.
- Flush in FULL together with in_valid=1 (instr C):
  - next cycle out_valid=0, in_ready=1.
  - C never appears on the outputs.
- Assert rst_n=0 between edges while FULL -> out_valid, in_ready and out_instr update immediately to 0, 1 and 0 without a clock edge.
- With IFID_STALL_COUNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_count=5; a flush leaves it at 5; forcing near all-ones saturates it.
